if_fetch_queue: RTL

//  Parametrised instruction-fetch front end: owns the fetch PC, drives IROM and buffers fetched

---
 rtl/if_fetch_queue.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction-fetch front end. Owns the fetch PC, addresses IROM and
// buffers fetched {pc, inst} pairs in a DEPTH-entry FIFO whose head feeds the ID stage.
// Ports:
//   cpu_clk, cpu_rst      clock, asynchronous active-low reset
//   inst_addr / inst      IROM word address out, IROM read data in
//   redirect_valid/_pc    flush and refetch from redirect_pc (bits [1:0] forced to 0)
//   id_ready              ID stage accepts the head entry this cycle
//   id_valid/_inst/_pc/_pc4  registered head entry (NOP_INST / 0 when empty)
//   occupancy             number of valid FIFO entries
module if_fetch_queue #(
   parameter int unsigned PC_W     = 32,
   parameter int unsigned INST_W   = 32,
   parameter int unsigned IADDR_W  = 14,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned ROM_LAT  = 0,
   parameter logic [PC_W-1:0]   RESET_PC = '0,
   parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h13)
) (
   input  logic                     cpu_clk,
   input  logic                     cpu_rst,
   output logic [IADDR_W-1:0]       inst_addr,
   input  logic [INST_W-1:0]        inst,
   input  logic                     redirect_valid,
   input  logic [PC_W-1:0]          redirect_pc,
   input  logic                     id_ready,
   output logic                     id_valid,
   output logic [INST_W-1:0]        id_inst,
   output logic [PC_W-1:0]          id_pc,
   output logic [PC_W-1:0]          id_pc4,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned OCC_W = PTR_W + 1;

   logic [PC_W-1:0]   pc_f_q, pc_f_d;
   logic [PC_W-1:0]   req_pc_q, req_pc_d;
   logic              inflight_q, inflight_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]  occ_q, occ_d;
   logic [INST_W-1:0] inst_mem_q [DEPTH];
   logic [INST_W-1:0] inst_mem_d [DEPTH];
   logic [PC_W-1:0]   pc_mem_q   [DEPTH];
   logic [PC_W-1:0]   pc_mem_d   [DEPTH];
   logic              id_valid_q, id_valid_d;
   logic [INST_W-1:0] id_inst_q, id_inst_d;
   logic [PC_W-1:0]   id_pc_q, id_pc_d;
   logic [PC_W-1:0]   id_pc4_q, id_pc4_d;

   logic              pop_c;
   logic              issue_c;
   logic              push_c;
   logic [PC_W-1:0]   push_pc_c;
   logic [OCC_W:0]    demand_c;

   assign inst_addr = pc_f_q[IADDR_W+1:2];
   assign id_valid  = id_valid_q;
   assign id_inst   = id_inst_q;
   assign id_pc     = id_pc_q;
   assign id_pc4    = id_pc4_q;
   assign occupancy = occ_q;

   // Handshake: issue only if the slot is guaranteed, counting an outstanding IROM return
   always_comb begin
      pop_c    = id_valid_q & id_ready & ~redirect_valid;
      demand_c = {1'b0, occ_q} + (OCC_W+1)'(inflight_q) - (OCC_W+1)'(pop_c);
      issue_c  = ~redirect_valid && (demand_c < (OCC_W+1)'(DEPTH));
      if (ROM_LAT == 0) begin
         push_c    = issue_c;
         push_pc_c = pc_f_q;
      end else begin
         // A return is squashed if a redirect lands on the cycle it arrives
         push_c    = inflight_q & ~redirect_valid;
         push_pc_c = req_pc_q;
      end
   end

   // Next state for PC, FIFO storage and registered head
   always_comb begin
      pc_f_d     = pc_f_q;
      req_pc_d   = req_pc_q;
      inflight_d = 1'b0;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      occ_d      = occ_q;
      inst_mem_d = inst_mem_q;
      pc_mem_d   = pc_mem_q;
      if (redirect_valid) begin
         pc_f_d   = redirect_pc & ~PC_W'(3);
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         occ_d    = '0;
      end else begin
         if (issue_c) begin
            pc_f_d     = pc_f_q + PC_W'(4);
            req_pc_d   = pc_f_q;
            inflight_d = (ROM_LAT != 0);
         end
         if (push_c) begin
            inst_mem_d[wr_ptr_q] = inst;
            pc_mem_d[wr_ptr_q]   = push_pc_c;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
         end
         if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         occ_d = occ_q + OCC_W'(push_c) - OCC_W'(pop_c);
      end
      // Head is read from the post-update storage so id_* are pure flops
      id_valid_d = (occ_d != '0);
      id_inst_d  = NOP_INST;
      id_pc_d    = '0;
      id_pc4_d   = '0;
      if (id_valid_d) begin
         id_inst_d = inst_mem_d[rd_ptr_d];
         id_pc_d   = pc_mem_d[rd_ptr_d];
         id_pc4_d  = pc_mem_d[rd_ptr_d] + PC_W'(4);
      end
   end

   // State registers
   always_ff @(posedge cpu_clk or negedge cpu_rst) begin
      if (!cpu_rst) begin
         pc_f_q     <= RESET_PC;
         req_pc_q   <= '0;
         inflight_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            inst_mem_q[i] <= '0;
            pc_mem_q[i]   <= '0;
         end
         id_valid_q <= 1'b0;
         id_inst_q  <= NOP_INST;
         id_pc_q    <= '0;
         id_pc4_q   <= '0;
      end else begin
         pc_f_q     <= pc_f_d;
         req_pc_q   <= req_pc_d;
         inflight_q <= inflight_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
         inst_mem_q <= inst_mem_d;
         pc_mem_q   <= pc_mem_d;
         id_valid_q <= id_valid_d;
         id_inst_q  <= id_inst_d;
         id_pc_q    <= id_pc_d;
         id_pc4_q   <= id_pc4_d;
      end
   end

endmodule
